butterfly_datapath: RTL and testbench
=====================================

# butterfly_datapath

Arithmetic datapath for the radix-2 FFT butterfly, computing Y = A + W·B and Z = A − W·B on complex signed fixed-point operands. It sits directly downstream of the butterfly sequencing FSM and consumes its one-cycle strobes. Each strobe loads an operand word, performs one arithmetic step, or drives one result component onto a registered, saturated display output.

## Interface
- DW, default 8: bits per real/imaginary component. Signed two's complement, Q1.(DW−1).
- Clock  input  1  single system clock; all state updates on its rising edge.
- nReset  input  1  asynchronous, active-low reset.
- DataIn  input  2·DW  operand word: [2DW−1:DW] = Re, [DW−1:0] = Im.
- store_W, store_B, store_A  input  1 each  load DataIn into the W, B, or A register pair.
- calc_ReWB, calc_ImY, calc_ImZ, calc_ReZ2, calc_ReZ, calc_ReY  input  1 each  arithmetic step strobes.
- display_ReY, display_ImY, display_ReZ, display_ImZ  input  1 each  select a result to register onto DataOut.
- clear  input  1  synchronous zeroing of operand and result registers.
- DataOut  output  DW  saturated result component. Reset value 0.
- Overflow  output  1  set when the value on DataOut was saturated. Reset value 0.

## Operation
- Internal registers:
  - Operands ReW, ImW, ReB, ImB, ReA, ImA: DW bits each.
  - Products ReWB, ImWB: DW+2 bits each.
  - Results ReY, ImY, ReZ, ImZ: DW+2 bits each.
  - All reset to 0.
- Product rule:
  - Multiply as full signed DW×DW → 2DW bits.
  - Form each sum or difference of two products in 2DW+1 bits.
  - Scale by an arithmetic right shift of DW−1 (floor truncation, no rounding), then keep the low DW+2 bits. The result is exact, since magnitude ≤ 2^DW.
- Sum rule: sign-extend A to DW+2 bits. Add or subtract in DW+2 bits; no internal overflow is possible.
- Strobe actions, on the rising edge where the strobe is high:
  - store_W: ReW, ImW ← DataIn.
  - store_B: ReB, ImB ← DataIn.
  - store_A: ReA, ImA ← DataIn.
  - calc_ReWB: ReWB ← (ReW·ReB − ImW·ImB) >>> (DW−1).
  - calc_ImY: ImWB ← (ReW·ImB + ImW·ReB) >>> (DW−1).
  - calc_ImZ: ImZ ← −ImWB. This holds the partial result, not ImZ.
  - calc_ReZ2: ReZ ← ReA − ReWB.
  - calc_ReZ: ImZ ← ImA + ImZ.
  - calc_ReY: ReY ← ReA + ReWB; ImY ← ImA + ImWB.
  - display_X: DataOut ← sat(X); Overflow ← 1 iff X lies outside [−2^(DW−1), 2^(DW−1)−1].
- Saturation: X > 2^(DW−1)−1 → 0x7F…; X < −2^(DW−1) → 0x80…; otherwise the low DW bits of X.
- Priority:
  - clear overrides every other strobe in the same cycle.
  - Otherwise, if several strobes are high, only the first one in the list order above acts. The upstream FSM guarantees one-hot strobes; this rule only defines behaviour when that guarantee is broken.
- clear zeroes all operand, product and result registers. DataOut and Overflow hold, so the last displayed value stays visible while the sequencer idles.
- No strobe high: all registers hold.

## Timing
- Every action is single-cycle. A register is updated at the edge ending the strobe cycle and is usable by the strobe in the following cycle.
- Minimum valid sequence from the sequencer:
  - store_W, store_B, calc_ReWB, calc_ImY, calc_ImZ;
  - then store_A, calc_ReZ2, calc_ReZ, calc_ReY;
  - then the display strobes.
  - Any idle cycles between these are allowed.
- DataIn is sampled only on the store_* edge and may change freely otherwise.
- DataOut and Overflow change one edge after the display strobe. They are registered, so there is no combinational path from the strobes.
- A display strobe issued before the corresponding calc step outputs the current register content (0 after clear or reset).
- nReset low, at any time including mid-sequence: all registers, DataOut and Overflow go to 0 immediately, independent of Clock. Operation resumes on the first edge after release.

## Test plan
All cases use DW=8.
- Nominal:
  - Stimulus: W=0x4000, B=0x4020, A=0x1008, full strobe sequence, then the four display strobes.
  - Required: ReY=0x30, ImY=0x18, ReZ=0xF0, ImZ=0xF8, with Overflow=0 on every display.
- Saturation:
  - Stimulus: W=0x8080, B=0x807F, A=0x7F00. This gives ReWB=255.
  - Required: display_ReY → 0x7F, Overflow=1; display_ReZ → 0x80, Overflow=0 (exact −128); ImY → 0x01; ImZ → 0xFF.
- Truncation:
  - Stimulus: W=0x0100, B=0xFF00, A=0x0000.
  - Required: ReWB=−1 (floor), ReY → 0xFF, ReZ → 0x01.
- Clear hold:
  - Stimulus: after the nominal display of ImZ (0xF8), hold clear for 5 cycles.
  - Required: DataOut stays 0xF8. A following display_ReY with no new calc outputs 0x00.
- Async reset:
  - Stimulus: assert nReset low between calc_ImY and calc_ImZ of the nominal run, mid-cycle.
  - Required: DataOut=0 and Overflow=0 before the next edge. After release, a re-run of the nominal sequence gives the nominal results.
- Priority:
  - Stimulus: clear and store_A high together, then store_W and store_B high together.
  - Required: the first cycle zeroes all registers and does not load A. The second cycle loads only W; B stays 0.

Source files
------------

// File: rtl/butterfly_datapath.sv
// Radix-2 FFT butterfly datapath: Y = A + W*B, Z = A - W*B on Q1.(DW-1) complex operands,
// stepped one strobe per cycle by the upstream sequencer, with a saturated registered display port.
module butterfly_datapath #(
  parameter int DW = 8
) (
  input  logic            Clock,
  input  logic            nReset,
  input  logic [2*DW-1:0] DataIn,
  input  logic            store_W,
  input  logic            store_B,
  input  logic            store_A,
  input  logic            calc_ReWB,
  input  logic            calc_ImY,
  input  logic            calc_ImZ,
  input  logic            calc_ReZ2,
  input  logic            calc_ReZ,
  input  logic            calc_ReY,
  input  logic            display_ReY,
  input  logic            display_ImY,
  input  logic            display_ReZ,
  input  logic            display_ImZ,
  input  logic            clear,
  output logic [DW-1:0]   DataOut,
  output logic            Overflow
);
  localparam int RW = DW + 2;
  localparam int PW = 2*DW + 1;

  typedef logic signed [DW-1:0] opd_t;
  typedef logic signed [RW-1:0] res_t;
  typedef logic signed [PW-1:0] prod_t;

  localparam res_t SMAX = res_t'(2**(DW-1) - 1);
  localparam res_t SMIN = res_t'(-(2**(DW-1)));

  opd_t re_w, im_w, re_b, im_b, re_a, im_a;
  res_t re_wb, im_wb, re_y, im_y, re_z, im_z;
  prod_t re_sum, im_sum;
  res_t  disp_sel;
  logic  disp_any;

  // Operands widened before multiplying so both products and their sum are exact in PW bits.
  assign re_sum = prod_t'(re_w) * prod_t'(re_b) - prod_t'(im_w) * prod_t'(im_b);
  assign im_sum = prod_t'(re_w) * prod_t'(im_b) + prod_t'(im_w) * prod_t'(re_b);

  always_comb begin
    disp_any = display_ReY | display_ImY | display_ReZ | display_ImZ;
    disp_sel = im_z;
    if (display_ReY)      disp_sel = re_y;
    else if (display_ImY) disp_sel = im_y;
    else if (display_ReZ) disp_sel = re_z;
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      re_w <= '0; im_w <= '0; re_b <= '0; im_b <= '0; re_a <= '0; im_a <= '0;
      re_wb <= '0; im_wb <= '0; re_y <= '0; im_y <= '0; re_z <= '0; im_z <= '0;
      DataOut  <= '0;
      Overflow <= 1'b0;
    end else if (clear) begin
      // Display registers deliberately hold so the last result stays visible.
      re_w <= '0; im_w <= '0; re_b <= '0; im_b <= '0; re_a <= '0; im_a <= '0;
      re_wb <= '0; im_wb <= '0; re_y <= '0; im_y <= '0; re_z <= '0; im_z <= '0;
    end else if (store_W) begin
      re_w <= DataIn[2*DW-1:DW]; im_w <= DataIn[DW-1:0];
    end else if (store_B) begin
      re_b <= DataIn[2*DW-1:DW]; im_b <= DataIn[DW-1:0];
    end else if (store_A) begin
      re_a <= DataIn[2*DW-1:DW]; im_a <= DataIn[DW-1:0];
    end else if (calc_ReWB) begin
      re_wb <= res_t'(re_sum >>> (DW-1));
    end else if (calc_ImY) begin
      im_wb <= res_t'(im_sum >>> (DW-1));
    end else if (calc_ImZ) begin
      im_z <= -im_wb;
    end else if (calc_ReZ2) begin
      re_z <= res_t'(re_a) - re_wb;
    end else if (calc_ReZ) begin
      im_z <= res_t'(im_a) + im_z;
    end else if (calc_ReY) begin
      re_y <= res_t'(re_a) + re_wb;
      im_y <= res_t'(im_a) + im_wb;
    end else if (disp_any) begin
      if (disp_sel > SMAX) begin
        DataOut  <= {1'b0, {(DW-1){1'b1}}};
        Overflow <= 1'b1;
      end else if (disp_sel < SMIN) begin
        DataOut  <= {1'b1, {(DW-1){1'b0}}};
        Overflow <= 1'b1;
      end else begin
        DataOut  <= disp_sel[DW-1:0];
        Overflow <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_butterfly_datapath.sv
// Directed bench for butterfly_datapath: integer reference model compared every cycle,
// plus literal expectations for the documented butterfly cases.
module tb_butterfly_datapath;
  localparam int DW = 8;

  // strobe bit positions, in priority order
  localparam int S_W = 0, S_B = 1, S_A = 2, C_REWB = 3, C_IMY = 4, C_IMZ = 5,
                 C_REZ2 = 6, C_REZ = 7, C_REY = 8, D_REY = 9, D_IMY = 10, D_REZ = 11, D_IMZ = 12;

  logic            Clock = 1'b0;
  logic            nReset = 1'b0;
  logic [2*DW-1:0] DataIn = '0;
  logic [12:0]     stb = '0;
  logic            clear = 1'b0;
  logic [DW-1:0]   DataOut;
  logic            Overflow;

  int checks = 0;
  int errors = 0;

  // reference state as plain integers
  int rew, imw, reb, imb, rea, ima, rewb, imwb, rey, imy, rez, imz, m_out, m_ovf;

  butterfly_datapath #(.DW(DW)) dut (
    .Clock(Clock), .nReset(nReset), .DataIn(DataIn),
    .store_W(stb[S_W]), .store_B(stb[S_B]), .store_A(stb[S_A]),
    .calc_ReWB(stb[C_REWB]), .calc_ImY(stb[C_IMY]), .calc_ImZ(stb[C_IMZ]),
    .calc_ReZ2(stb[C_REZ2]), .calc_ReZ(stb[C_REZ]), .calc_ReY(stb[C_REY]),
    .display_ReY(stb[D_REY]), .display_ImY(stb[D_IMY]),
    .display_ReZ(stb[D_REZ]), .display_ImZ(stb[D_IMZ]),
    .clear(clear), .DataOut(DataOut), .Overflow(Overflow)
  );

  always #5 Clock = ~Clock;

  function automatic int sx(input logic [DW-1:0] v);
    return int'($signed(v));
  endfunction

  task automatic model_reset();
    rew = 0; imw = 0; reb = 0; imb = 0; rea = 0; ima = 0;
    rewb = 0; imwb = 0; rey = 0; imy = 0; rez = 0; imz = 0;
  endtask

  task automatic model_step(input logic [12:0] s, input logic c, input logic [2*DW-1:0] d);
    int x;
    int first;
    if (c) begin
      model_reset();
      return;
    end
    first = -1;
    for (int i = 12; i >= 0; i--) if (s[i]) first = i;
    x = 0;
    case (first)
      S_W:    begin rew = sx(d[15:8]); imw = sx(d[7:0]); end
      S_B:    begin reb = sx(d[15:8]); imb = sx(d[7:0]); end
      S_A:    begin rea = sx(d[15:8]); ima = sx(d[7:0]); end
      C_REWB: rewb = (rew*reb - imw*imb) >>> (DW-1);
      C_IMY:  imwb = (rew*imb + imw*reb) >>> (DW-1);
      C_IMZ:  imz = -imwb;
      C_REZ2: rez = rea - rewb;
      C_REZ:  imz = ima + imz;
      C_REY:  begin rey = rea + rewb; imy = ima + imwb; end
      default: ;
    endcase
    if (first >= D_REY) begin
      case (first)
        D_REY: x = rey;
        D_IMY: x = imy;
        D_REZ: x = rez;
        default: x = imz;
      endcase
      m_ovf = (x > 127 || x < -128) ? 1 : 0;
      m_out = (x > 127) ? 127 : (x < -128) ? -128 : x;
    end
  endtask

  // one cycle: drive just after the edge, update the model at the next edge
  task automatic step(input logic [12:0] s, input logic c = 1'b0, input logic [2*DW-1:0] d = '0);
    stb = s; clear = c; DataIn = d;
    @(posedge Clock);
    model_step(s, c, d);
    #2;
    stb = '0; clear = 1'b0; DataIn = 16'hxxxx;
  endtask

  task automatic run_calc(input logic [15:0] w, input logic [15:0] b, input logic [15:0] a);
    step(13'(1) << S_W, 1'b0, w);
    step(13'(1) << S_B, 1'b0, b);
    step(13'(1) << C_REWB);
    step(13'(1) << C_IMY);
    step(13'(1) << C_IMZ);
    step('0);
    step(13'(1) << S_A, 1'b0, a);
    step(13'(1) << C_REZ2);
    step(13'(1) << C_REZ);
    step(13'(1) << C_REY);
  endtask

  task automatic expect_out(input string name, input logic [7:0] exp_d, input logic exp_o);
    @(negedge Clock);
    checks++;
    if (DataOut !== exp_d || Overflow !== exp_o) begin
      errors++;
      $display("FAIL %s: got DataOut=%02h Overflow=%0b, want %02h %0b", name, DataOut, Overflow, exp_d, exp_o);
    end
  endtask

  task automatic show(input int which, input string name, input logic [7:0] exp_d, input logic exp_o);
    step(13'(1) << which);
    expect_out(name, exp_d, exp_o);
  endtask

  // cycle-by-cycle comparison against the model whenever out of reset
  always @(negedge Clock) begin
    if (nReset) begin
      checks++;
      if (DataOut !== m_out[7:0] || Overflow !== m_ovf[0]) begin
        errors++;
        $display("FAIL model_cmp @%0t: got %02h/%0b, model %02h/%0b", $time, DataOut, Overflow,
                 m_out[7:0], m_ovf[0]);
      end
    end
  end

  initial begin
    model_reset(); m_out = 0; m_ovf = 0;
    #3;
    checks++;
    if (DataOut !== 8'h00 || Overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got %02h/%0b, want 00/0", DataOut, Overflow);
    end
    @(posedge Clock); #2; nReset = 1'b1;

    // nominal
    run_calc(16'h4000, 16'h4020, 16'h1008);
    show(D_REY, "nom_ReY", 8'h30, 1'b0);
    show(D_IMY, "nom_ImY", 8'h18, 1'b0);
    show(D_REZ, "nom_ReZ", 8'hF0, 1'b0);
    show(D_IMZ, "nom_ImZ", 8'hF8, 1'b0);

    // clear holds the display, then registers read back as zero
    for (int i = 0; i < 5; i++) begin
      step('0, 1'b1);
      expect_out("clear_hold", 8'hF8, 1'b0);
    end
    show(D_REY, "after_clear_ReY", 8'h00, 1'b0);

    // saturation
    run_calc(16'h8080, 16'h807F, 16'h7F00);
    show(D_REY, "sat_ReY", 8'h7F, 1'b1);
    show(D_REZ, "sat_ReZ", 8'h80, 1'b0);
    show(D_IMY, "sat_ImY", 8'h01, 1'b0);
    show(D_IMZ, "sat_ImZ", 8'hFF, 1'b0);

    // floor truncation of the product
    run_calc(16'h0100, 16'hFF00, 16'h0000);
    show(D_REY, "trunc_ReY", 8'hFF, 1'b0);
    show(D_REZ, "trunc_ReZ", 8'h01, 1'b0);

    // async reset mid-sequence
    step(13'(1) << S_W, 1'b0, 16'h4000);
    step(13'(1) << S_B, 1'b0, 16'h4020);
    step(13'(1) << C_REWB);
    step(13'(1) << C_IMY);
    nReset = 1'b0;
    model_reset(); m_out = 0; m_ovf = 0;
    #1;
    checks++;
    if (DataOut !== 8'h00 || Overflow !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got %02h/%0b, want 00/0", DataOut, Overflow);
    end
    @(posedge Clock); @(posedge Clock); #2;
    nReset = 1'b1;
    run_calc(16'h4000, 16'h4020, 16'h1008);
    show(D_REY, "rerun_ReY", 8'h30, 1'b0);
    show(D_IMZ, "rerun_ImZ", 8'hF8, 1'b0);

    // priority: clear beats store_A, store_W beats store_B
    step(13'(1) << S_A, 1'b1, 16'h3000);
    step((13'(1) << S_W) | (13'(1) << S_B), 1'b0, 16'h4000);
    step(13'(1) << C_REWB);
    step(13'(1) << C_REY);
    show(D_REY, "prio_zero", 8'h00, 1'b0);
    step(13'(1) << S_B, 1'b0, 16'h4000);
    step(13'(1) << C_REWB);
    step(13'(1) << C_REY);
    show(D_REY, "prio_w_loaded", 8'h20, 1'b0);

    @(negedge Clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
